// File: rtl/y86_mem_responder.sv
// Unified byte-addressed memory for a Y86 core: image loader port, 32-bit data port
// and a wide instruction fetch port, sequenced by an IDLE/LOAD/RUN controller.
module y86_mem_responder #(
  parameter int MEM_BYTES  = 256,
  parameter int INST_BYTES = 6
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    mem_read,
  input  logic                    mem_write,
  input  logic [7:0]              mem_addr,
  input  logic [31:0]             mem_wdata,
  output logic [31:0]             mem_rdata,
  input  logic [31:0]             rom_addr,
  output logic [8*INST_BYTES-1:0] rom_data,
  input  logic                    load_start,
  input  logic                    load_valid,
  input  logic [7:0]              load_byte,
  input  logic                    load_done,
  output logic                    load_ready,
  output logic                    busy,
  output logic [8:0]              load_count
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} stateT;

  stateT      state;
  logic [8:0] loadCount;
  logic [7:0] mem [MEM_BYTES];
  logic       loadAccept;
  logic [7:0] romPtr;
  logic       unusedRomBits;

  assign romPtr        = rom_addr[7:0];
  assign unusedRomBits = ^rom_addr[31:8];

  assign load_count = loadCount;
  assign busy       = (state != RUN);
  assign load_ready = (state == LOAD) && (loadCount < 9'(MEM_BYTES));
  // A restart in the same cycle wins over a presented byte, so nothing lands at the old address.
  assign loadAccept = load_ready && load_valid && !load_start;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      loadCount <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (load_start) begin
            state     <= LOAD;
            loadCount <= '0;
          end else if (load_done) begin
            state <= RUN;
          end
        end
        LOAD: begin
          if (load_start) begin
            loadCount <= '0;
          end else begin
            if (loadAccept) loadCount <= loadCount + 9'd1;
            if (load_done) state <= RUN;
          end
        end
        RUN: begin
          if (load_start) begin
            state     <= LOAD;
            loadCount <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the storage array has no reset branch; a loaded image must survive reset, and
  // a reset cycle itself blocks every write.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (loadAccept) mem[loadCount[7:0]] <= load_byte;
      if (state == RUN && mem_write) begin
        for (int i = 0; i < 4; i++) mem[mem_addr + 8'(i)] <= mem_wdata[8*i +: 8];
      end
    end
  end

  // NOTE: combinational outputs assign a default first so no latch is inferred.
  always_comb begin
    mem_rdata = '0;
    if (state == RUN && mem_read) begin
      for (int i = 0; i < 4; i++) mem_rdata[8*i +: 8] = mem[mem_addr + 8'(i)];
    end
  end

  // Fetch is big-endian on the bus: the byte at the fetch pointer sits in the top lane.
  always_comb begin
    rom_data = '0;
    if (state == RUN) begin
      for (int i = 0; i < INST_BYTES; i++) rom_data[8*(INST_BYTES-1-i) +: 8] = mem[romPtr + 8'(i)];
    end
  end

endmodule

// File: tb/tb_y86_mem_responder.sv
// Self-checking bench for y86_mem_responder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a byte-array reference model.
module tb_y86_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read, mem_write;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] rom_addr;
  logic [47:0] rom_data;
  logic        load_start, load_valid, load_done;
  logic [7:0]  load_byte;
  logic        load_ready, busy;
  logic [8:0]  load_count;

  always #5 clk = ~clk;

  y86_mem_responder dut (
    .clk(clk), .rst(rst),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .rom_addr(rom_addr), .rom_data(rom_data),
    .load_start(load_start), .load_valid(load_valid), .load_byte(load_byte),
    .load_done(load_done), .load_ready(load_ready), .busy(busy), .load_count(load_count)
  );

  int checks = 0;
  int failures = 0;
  bit checkEn = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp,
                       input logic [63:0] mask = '1);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      failures++;
      $display("FAIL %s: got %h expected %h (mask %h) at %0t", name, act & mask, exp & mask, mask, $time);
    end
  endtask

  // Reference model: state name, byte count and a byte array with a known-flag per byte.
  localparam int S_IDLE = 0, S_LOAD = 1, S_RUN = 2;
  int         refSt  = S_IDLE;
  int         refCnt = 0;
  logic [7:0] refMem [256];
  bit         refKnown [256];

  function automatic void refWord(input int a, output logic [31:0] v, output logic [31:0] m);
    v = '0; m = '0;
    for (int i = 0; i < 4; i++) begin
      v[8*i +: 8] = refMem[(a + i) % 256];
      m[8*i +: 8] = refKnown[(a + i) % 256] ? 8'hFF : 8'h00;
    end
  endfunction

  function automatic void refFetch(input int p, output logic [47:0] v, output logic [47:0] m);
    v = '0; m = '0;
    for (int i = 0; i < 6; i++) begin
      v[8*(5-i) +: 8] = refMem[(p + i) % 256];
      m[8*(5-i) +: 8] = refKnown[(p + i) % 256] ? 8'hFF : 8'h00;
    end
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      refSt  = S_IDLE;
      refCnt = 0;
    end else if (refSt == S_IDLE) begin
      if (load_start) begin refSt = S_LOAD; refCnt = 0; end
      else if (load_done) refSt = S_RUN;
    end else if (refSt == S_LOAD) begin
      if (load_start) refCnt = 0;
      else begin
        if (load_valid && refCnt < 256) begin
          refMem[refCnt]   = load_byte;
          refKnown[refCnt] = 1'b1;
          refCnt++;
        end
        if (load_done) refSt = S_RUN;
      end
    end else begin
      if (mem_write) begin
        for (int i = 0; i < 4; i++) begin
          refMem[(int'(mem_addr) + i) % 256]   = mem_wdata[8*i +: 8];
          refKnown[(int'(mem_addr) + i) % 256] = 1'b1;
        end
      end
      if (load_start) begin refSt = S_LOAD; refCnt = 0; end
    end
  end

  always @(negedge clk) begin
    logic [31:0] ev, em;
    logic [47:0] fv, fm;
    if (checkEn) begin
      check("busy", 64'(busy), 64'(refSt != S_RUN));
      check("load_ready", 64'(load_ready), 64'(refSt == S_LOAD && refCnt < 256));
      check("load_count", 64'(load_count), 64'(refCnt));
      if (refSt == S_RUN && mem_read) refWord(int'(mem_addr), ev, em);
      else begin ev = '0; em = '1; end
      check("mem_rdata", 64'(mem_rdata), 64'(ev), 64'(em));
      if (refSt == S_RUN) refFetch(int'(rom_addr[7:0]), fv, fm);
      else begin fv = '0; fm = '1; end
      check("rom_data", 64'(rom_data), 64'(fv), 64'(fm));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cpuWrite(input logic [7:0] a, input logic [31:0] d);
    mem_write = 1'b1; mem_addr = a; mem_wdata = d;
    step();
    mem_write = 1'b0;
  endtask

  task automatic readCheck(input string name, input logic [7:0] a, input logic [31:0] exp,
                           input logic [31:0] mask = '1);
    mem_read = 1'b1; mem_addr = a;
    @(negedge clk);
    check(name, 64'(mem_rdata), 64'(exp), 64'(mask));
    step();
    mem_read = 1'b0;
  endtask

  logic [7:0] prog [6] = '{8'h30, 8'hF0, 8'h01, 8'h00, 8'h00, 8'h00};
  logic [7:0] stream [300];

  initial begin
    rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wdata = '0;
    rom_addr = '0; load_start = 1'b0; load_valid = 1'b0; load_byte = '0; load_done = 1'b0;
    step();
    checkEn = 1'b1;
    @(negedge clk);
    check("reset_busy", 64'(busy), 64'd1);
    check("reset_count", 64'(load_count), 64'd0);
    check("reset_rom", 64'(rom_data), 64'd0);
    rst = 1'b1;
    step();

    // Small program image, then fetch at 0.
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1'b1; load_byte = prog[i]; step();
    end
    load_valid = 1'b0; load_done = 1'b1; step(); load_done = 1'b0;
    rom_addr = 32'h0;
    @(negedge clk);
    check("prog_count", 64'(load_count), 64'd6);
    check("prog_busy", 64'(busy), 64'd0);
    check("prog_fetch", 64'(rom_data), 64'h30F001000000);
    step();

    cpuWrite(8'h10, 32'hDEADBEEF);
    readCheck("rd_10", 8'h10, 32'hDEADBEEF);
    readCheck("rd_10_byte", 8'h10, 32'h000000EF, 32'h000000FF);
    readCheck("rd_11", 8'h11, 32'h00DEADBE, 32'h00FFFFFF);

    cpuWrite(8'hFA, 32'hBBAA9988);
    cpuWrite(8'hFE, 32'h11223344);
    readCheck("rd_fe_wrap", 8'hFE, 32'h11223344);
    readCheck("rd_00_wrap", 8'h00, 32'h00011122);
    rom_addr = 32'h0000_01FC;
    @(negedge clk);
    check("fetch_wrap", 64'(rom_data), 64'hAABB44332211);
    step();

    cpuWrite(8'h20, 32'h0);
    mem_read = 1'b1; mem_write = 1'b1; mem_addr = 8'h20; mem_wdata = 32'h5;
    @(negedge clk);
    check("rw_same_cycle", 64'(mem_rdata), 64'd0);
    step(); mem_write = 1'b0;
    @(negedge clk);
    check("rw_next_read", 64'(mem_rdata), 64'd5);
    step(); mem_read = 1'b0;

    load_start = 1'b1; step(); load_start = 1'b0;
    cpuWrite(8'h20, 32'h99);
    load_done = 1'b1; step(); load_done = 1'b0;
    readCheck("write_in_load", 8'h20, 32'h5);

    // Overlong image: 300 bytes offered, only 256 accepted.
    load_start = 1'b1; step(); load_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      stream[i] = (i < 256) ? 8'($urandom) : ~stream[0];
      load_valid = 1'b1; load_byte = stream[i];
      if (i == 255 || i == 256) begin
        @(negedge clk);
        check("full_count", 64'(load_count), 64'(i));
        check("full_ready", 64'(load_ready), (i == 255) ? 64'd1 : 64'd0);
      end
      step();
    end
    load_valid = 1'b0; load_done = 1'b1; step(); load_done = 1'b0;
    readCheck("overflow_addr0", 8'h00, {24'h0, stream[0]}, 32'h000000FF);

    // Reset in the middle of a load.
    load_start = 1'b1; step(); load_start = 1'b0;
    load_valid = 1'b1;
    load_byte = 8'hA1; step();
    load_byte = 8'hB2; step();
    load_byte = 8'hC3; step();
    rst = 1'b0; load_byte = 8'hEE; step();
    rst = 1'b1; load_valid = 1'b0;
    @(negedge clk);
    check("abort_count", 64'(load_count), 64'd0);
    check("abort_busy", 64'(busy), 64'd1);
    load_done = 1'b1; step(); load_done = 1'b0;
    readCheck("abort_image", 8'h00, {stream[3], 24'hC3B2A1});

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 99) != 0);
      load_start = ($urandom_range(0, 59) == 0);
      load_done  = ($urandom_range(0, 19) == 0);
      load_valid = 1'($urandom);
      load_byte  = 8'($urandom);
      mem_read   = 1'($urandom);
      mem_write  = ($urandom_range(0, 3) == 0);
      mem_addr   = 8'($urandom);
      mem_wdata  = $urandom;
      rom_addr   = $urandom;
      step();
    end

    rst = 1'b1; load_start = 1'b0; load_done = 1'b0; load_valid = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
